// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared buffer state codes and default widths for the sync_fifo read-stream slice.
package fifo_rd_stream_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: sync_fifo read port plus the valid/ready stream, master = stream producer.
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          fifo_rempty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rdata_valid;
  logic          fifo_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    buf_level;
  modport master (
    input  fifo_rempty, fifo_rdata, fifo_rdata_valid, out_ready,
    output fifo_rd, out_valid, out_data, out_last, buf_level
  );
  modport slave (
    output fifo_rempty, fifo_rdata, fifo_rdata_valid, out_ready,
    input  fifo_rd, out_valid, out_data, out_last, buf_level
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order skid buffer; head_q is always the oldest word.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    level
);
  buf_state_t    state_q;
  logic [DW-1:0] head_q, tail_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      state_q <= BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (push) begin
          head_q  <= din;
          state_q <= BUF_ONE;
        end
        BUF_ONE: if (push && pop) begin
          head_q <= din;
        end else if (push) begin
          tail_q  <= din;
          state_q <= BUF_FULL;
        end else if (pop) begin
          state_q <= BUF_EMPTY;
        end
        BUF_FULL: if (pop) begin
          head_q  <= tail_q;
          state_q <= BUF_ONE;
        end
        default: state_q <= BUF_EMPTY;
      endcase
    end
  end
  assign dout  = head_q;
  assign level = state_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains sync_fifo into a valid/ready stream at 1 word/clk.
// Optional burst out_last generation enabled by `define FIFO_RD_LAST_EN.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int BURST_LEN = 8,
  parameter int CW        = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  fifo_rd_stream_if.master bus
);
  logic       rd_pend_q;
  logic       rd, cap, pop;
  logic [1:0] level;
  assign pop = bus.out_valid & bus.out_ready;
  assign cap = rd_pend_q & bus.fifo_rdata_valid;
  // Count the in-flight word as occupied so a capture always finds a free slot;
  // reset_n gates the request so it drops with the rest of the state.
  assign rd = reset_n & ~bus.fifo_rempty & ~flush &
              ({1'b0, level} + {2'b0, rd_pend_q} < 3'd2 + {2'b0, pop});
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_pend_q <= 1'b0;
    else          rd_pend_q <= rd & ~flush;
  end
  fifo_rd_skid #(.DW(DW)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (cap),
    .pop     (pop),
    .din     (bus.fifo_rdata),
    .dout    (bus.out_data),
    .level   (level)
  );
  assign bus.fifo_rd   = rd;
  assign bus.out_valid = level != 2'd0;
  assign bus.buf_level = level;
`ifdef FIFO_RD_LAST_EN
  logic [CW-1:0] beat_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  beat_q <= '0;
    else if (flush) beat_q <= '0;
    else if (pop)   beat_q <= bus.out_last ? '0 : beat_q + 1'b1;
  end
  assign bus.out_last = bus.out_valid & (beat_q == CW'(BURST_LEN - 1));
`else
  logic unused_cfg;
  assign unused_cfg   = ^{BURST_LEN[0], CW[0]};
  assign bus.out_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a behavioural sync_fifo read port.
module tb_fifo_rd_stream;
  logic clk = 1'b0;
  logic reset_n, flush;
  int   checks = 0;
  int   errors = 0;
  fifo_rd_stream_if #(.DW(16)) bus ();
  fifo_rd_stream #(.DW(16), .BURST_LEN(4), .CW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  // Registered-read FIFO model: data and valid appear the cycle after an accepted fifo_rd.
  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_rempty = (rd_ptr == wr_ptr);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= wr_ptr;
      bus.fifo_rdata_valid <= 1'b0;
      bus.fifo_rdata <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      bus.fifo_rdata_valid <= 1'b0;
    end else begin
      bus.fifo_rdata_valid <= bus.fifo_rd;
      if (bus.fifo_rd) begin
        bus.fifo_rdata <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end
  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic exp_last;
    reset_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_level", bus.buf_level, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rd", bus.fifo_rd, 0);
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_level", bus.buf_level, 0);
    end
    // Streaming with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'(i));
    #1;
    chk("t2_rd_first", bus.fifo_rd, 1);
    chk("t2_valid_pre", bus.out_valid, 0);
    @(negedge clk);
    chk("t2_valid_inflight", bus.out_valid, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t2_valid", bus.out_valid, 1);
      chk("t2_data", bus.out_data, k);
    end
    @(negedge clk);
    chk("t2_drained", bus.out_valid, 0);
    // Backpressure: buffer fills to 2 and holds
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(16'(i));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t3_level", bus.buf_level, 2);
      chk("t3_rd", bus.fifo_rd, 0);
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_data", bus.out_data, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      chk("t3_rel_valid", bus.out_valid, 1);
      chk("t3_rel_data", bus.out_data, k);
      @(negedge clk);
    end
    chk("t3_drained", bus.out_valid, 0);
    // Flush with one word held and one in flight
    bus.out_ready = 1'b0;
    push(16'h00A1); push(16'h00A2); push(16'h00A3);
    repeat (2) @(negedge clk);
    chk("t4_pre_level", bus.buf_level, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_level", bus.buf_level, 0);
    chk("t4_valid", bus.out_valid, 0);
    push(16'h00B1);
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_wait", bus.out_valid, 1);
    chk("t4_data", bus.out_data, 16'h00B1);
    @(negedge clk);
    chk("t4_no_stale", bus.out_valid, 0);
    // Burst marking with toggling ready; flush first to zero the beat counter
    bus.out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 1; i <= 9; i++) push(16'h0050 + 16'(i));
    n = 0;
    for (int c = 0; c < 80 && n < 9; c++) begin
      bus.out_ready = (c % 2 == 0);
      if (bus.out_valid && bus.out_ready) begin
        n++;
`ifdef FIFO_RD_LAST_EN
        exp_last = (n == 4 || n == 8);
`else
        exp_last = 1'b0;
`endif
        chk("t5_data", bus.out_data, 16'h0050 + n);
        chk("t5_last", bus.out_last, exp_last);
      end
      @(negedge clk);
    end
    chk("t5_count", n, 9);
    // Asynchronous reset mid-stream
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'h0060 + 16'(i));
    repeat (2) @(negedge clk);
    chk("t6_pre_valid", bus.out_valid, 1);
    chk("t6_pre_rd", bus.fifo_rd, 1);
    chk("t6_pre_level", bus.buf_level, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_rd", bus.fifo_rd, 0);
    chk("t6_level", bus.buf_level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
